// File: rtl/tp_pkg.sv
// Shared definitions for the crossing loader: block codes, loader states, default depth.
package tp_pkg;

  localparam int DEPTH_DEF = 32;

  typedef enum logic [1:0] {
    BLK_A       = 2'd0,
    BLK_B       = 2'd1,
    BLK_C       = 2'd2,
    BLK_DISCARD = 2'd3
  } blk_e;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_ACK = 2'd2,
    DRAIN    = 2'd3
  } ldr_state_e;

endpackage

// File: rtl/tp_blk_ptr.sv
// Write/read pointer pair for one tracklet block, with empty/full status and sticky overflow.
module tp_blk_ptr #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          wr_req,
  input  logic          rd_req,
  input  logic          clr,
  output logic          zero,
  output logic          full,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic          ovf
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [AW:0] wr_cnt;
  logic [AW:0] rd_cnt;

  assign zero    = (rd_cnt == wr_cnt);
  assign full    = (wr_cnt == FULL_CNT);
  assign wr_addr = wr_cnt[AW-1:0];
  assign rd_addr = rd_cnt[AW-1:0];

  // Clear has priority: a crossing ending in DRAIN discards any read issued that cycle.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      ovf    <= 1'b0;
    end else if (clr) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_req) begin
        if (full) ovf    <= 1'b1;
        else      wr_cnt <= wr_cnt + ONE;
      end
      if (rd_req && !zero) rd_cnt <= rd_cnt + ONE;
    end
  end

endmodule

// File: rtl/tp_crossing_loader.sv
// Collects tracklets into three RAM blocks, hands the crossing to the processor, then recycles.
module tp_crossing_loader
  import tp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          trk_valid,
  input  logic [1:0]    trk_blk,
  input  logic          trk_last,
  output logic          trk_ready,
  output logic          wr_en,
  output logic [1:0]    wr_blk,
  output logic [AW-1:0] wr_addr,
  output logic          start_proc,
  input  logic          proc_bsy,
  input  logic          cnt_en_a,
  input  logic          cnt_en_b,
  input  logic          cnt_en_c,
  output logic          zero_a,
  output logic          zero_b,
  output logic          zero_c,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [AW-1:0] rd_addr_c,
  output logic [2:0]    ovf,
  output logic          ldr_bsy
);

  ldr_state_e    state;
  logic          accept;
  logic          rd_win;
  logic          clr;
  logic [2:0]    sel;
  logic [2:0]    cnt_en;
  logic [2:0]    full;
  logic [2:0]    zero;
  logic [AW-1:0] wa [3];
  logic [AW-1:0] ra [3];

  assign trk_ready = (state == COLLECT);
  assign ldr_bsy   = (state != COLLECT);
  assign accept    = trk_valid && trk_ready;
  assign rd_win    = (state == WAIT_ACK) || (state == DRAIN);
  assign clr       = (state == DRAIN) && !proc_bsy;
  assign cnt_en    = {cnt_en_c, cnt_en_b, cnt_en_a};

  for (genvar i = 0; i < 3; i++) begin : g_blk
    assign sel[i] = accept && (trk_blk == 2'(i));

    tp_blk_ptr #(.DEPTH(DEPTH), .AW(AW)) u_ptr (
      .clk     (clk),
      .res_n   (res_n),
      .wr_req  (sel[i]),
      .rd_req  (cnt_en[i] && rd_win),
      .clr     (clr),
      .zero    (zero[i]),
      .full    (full[i]),
      .wr_addr (wa[i]),
      .rd_addr (ra[i]),
      .ovf     (ovf[i])
    );
  end

  assign zero_a    = zero[0];
  assign zero_b    = zero[1];
  assign zero_c    = zero[2];
  assign rd_addr_a = ra[0];
  assign rd_addr_b = ra[1];
  assign rd_addr_c = ra[2];
  assign wr_blk    = trk_blk;

  // Discarded or overflowing tracklets are consumed without a RAM write.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    case (trk_blk)
      BLK_A:   begin wr_en = sel[0] && !full[0]; wr_addr = wa[0]; end
      BLK_B:   begin wr_en = sel[1] && !full[1]; wr_addr = wa[1]; end
      BLK_C:   begin wr_en = sel[2] && !full[2]; wr_addr = wa[2]; end
      default: begin wr_en = 1'b0;               wr_addr = '0;    end
    endcase
  end

  // start_proc is registered, so it is seen in the first WAIT_ACK cycle.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state      <= COLLECT;
      start_proc <= 1'b0;
    end else begin
      start_proc <= 1'b0;
      case (state)
        COLLECT:  if (accept && trk_last) state <= LAUNCH;
        LAUNCH:   if (!proc_bsy) begin
                    start_proc <= 1'b1;
                    state      <= WAIT_ACK;
                  end
        WAIT_ACK: if (proc_bsy) state <= DRAIN;
        DRAIN:    if (!proc_bsy) state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_tp_crossing_loader.sv
// Bench for tp_crossing_loader: directed vector table, corner sequences, randomized run against a model.
module tb_tp_crossing_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          res_n = 1'b0;
  logic          trk_valid = 1'b0;
  logic [1:0]    trk_blk = 2'd0;
  logic          trk_last = 1'b0;
  logic          trk_ready;
  logic          wr_en;
  logic [1:0]    wr_blk;
  logic [AW-1:0] wr_addr;
  logic          start_proc;
  logic          proc_bsy = 1'b0;
  logic          cnt_en_a = 1'b0, cnt_en_b = 1'b0, cnt_en_c = 1'b0;
  logic          zero_a, zero_b, zero_c;
  logic [AW-1:0] rd_addr_a, rd_addr_b, rd_addr_c;
  logic [2:0]    ovf;
  logic          ldr_bsy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tp_crossing_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .res_n(res_n),
    .trk_valid(trk_valid), .trk_blk(trk_blk), .trk_last(trk_last), .trk_ready(trk_ready),
    .wr_en(wr_en), .wr_blk(wr_blk), .wr_addr(wr_addr), .start_proc(start_proc),
    .proc_bsy(proc_bsy), .cnt_en_a(cnt_en_a), .cnt_en_b(cnt_en_b), .cnt_en_c(cnt_en_c),
    .zero_a(zero_a), .zero_b(zero_b), .zero_c(zero_c),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
    .ovf(ovf), .ldr_bsy(ldr_bsy)
  );

  typedef struct packed {
    logic       v;
    logic [1:0] blk;
    logic       last;
    logic       bsy;
    logic [2:0] en;
    logic       ready;
    logic       wen;
    logic [4:0] waddr;
    logic       start;
    logic [2:0] zero;
    logic [4:0] rda;
    logic       lbsy;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic setin(input logic v, input logic [1:0] blk, input logic last,
                       input logic bsy, input logic [2:0] en);
    trk_valid = v; trk_blk = blk; trk_last = last; proc_bsy = bsy;
    {cnt_en_c, cnt_en_b, cnt_en_a} = en;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    setin(1'b0, 2'd0, 1'b0, 1'b0, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", 32'(start_proc), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_zero", 32'({zero_c, zero_b, zero_a}), 32'h7);
    chk("rst_ready", 32'(trk_ready), 32'd1);
    chk("rst_ldr_bsy", 32'(ldr_bsy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    res_n = 1'b1;
  endtask

  task automatic run_table();
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 5'd0, 1'b0, 3'b111, 5'd0, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 5'd1, 1'b0, 3'b110, 5'd0, 1'b0};
    tbl[2]  = '{1'b1, 2'd1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 5'd0, 1'b0, 3'b110, 5'd0, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 3'b100, 5'd0, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b1, 3'b100, 5'd0, 1'b1};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 5'd0, 1'b0, 3'b100, 5'd0, 1'b1};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 5'd0, 1'b0, 3'b100, 5'd1, 1'b1};
    tbl[7]  = '{1'b0, 2'd0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 5'd0, 1'b0, 3'b101, 5'd2, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 5'd0, 1'b0, 3'b111, 5'd2, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 3'b111, 5'd2, 1'b1};
    tbl[10] = '{1'b1, 2'd3, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 5'd0, 1'b0, 3'b111, 5'd0, 1'b0};
    tbl[11] = '{1'b1, 2'd2, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1, 5'd0, 1'b0, 3'b111, 5'd0, 1'b0};
    tbl[12] = '{1'b0, 2'd0, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 5'd0, 1'b0, 3'b011, 5'd0, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 5'd0, 1'b0, 3'b011, 5'd0, 1'b0};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      setin(tbl[i].v, tbl[i].blk, tbl[i].last, tbl[i].bsy, tbl[i].en);
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(trk_ready), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].wen));
      if (tbl[i].wen) chk($sformatf("tbl%0d_wr_addr", i), 32'(wr_addr), 32'(tbl[i].waddr));
      chk($sformatf("tbl%0d_start", i), 32'(start_proc), 32'(tbl[i].start));
      chk($sformatf("tbl%0d_zero", i), 32'({zero_c, zero_b, zero_a}), 32'(tbl[i].zero));
      chk($sformatf("tbl%0d_rd_addr_a", i), 32'(rd_addr_a), 32'(tbl[i].rda));
      chk($sformatf("tbl%0d_ldr_bsy", i), 32'(ldr_bsy), 32'(tbl[i].lbsy));
      step();
    end
  endtask

  task automatic seq_overflow();
    do_reset();
    for (int k = 0; k <= DEPTH; k++) begin
      setin(1'b1, 2'd1, (k == DEPTH), 1'b0, 3'b000);
      #1;
      chk($sformatf("ovfseq_wr_en%0d", k), 32'(wr_en), 32'(k < DEPTH));
      if (k < DEPTH) chk($sformatf("ovfseq_wr_addr%0d", k), 32'(wr_addr), 32'(k));
      step();
    end
    setin(1'b0, 2'd0, 1'b0, 1'b0, 3'b000); #1;
    chk("ovfseq_ovf_launch", 32'(ovf), 32'h2);
    chk("ovfseq_zero_b", 32'(zero_b), 32'd0);
    step();
    setin(1'b0, 2'd0, 1'b0, 1'b1, 3'b000); #1;
    chk("ovfseq_start", 32'(start_proc), 32'd1);
    step();
    for (int k = 0; k < 3; k++) begin
      setin(1'b0, 2'd0, 1'b0, 1'b1, 3'b010); #1;
      chk("ovfseq_ovf_drain", 32'(ovf), 32'h2);
      step();
    end
    // processor releases while a tracklet is offered: it must not be taken
    setin(1'b1, 2'd0, 1'b1, 1'b0, 3'b000); #1;
    chk("ovfseq_drain_ready", 32'(trk_ready), 32'd0);
    chk("ovfseq_drain_wr_en", 32'(wr_en), 32'd0);
    chk("ovfseq_ovf_last", 32'(ovf), 32'h2);
    step();
    setin(1'b0, 2'd0, 1'b0, 1'b0, 3'b000); #1;
    chk("ovfseq_ovf_cleared", 32'(ovf), 32'h0);
    chk("ovfseq_zero_a", 32'(zero_a), 32'd1);
    chk("ovfseq_ldr_bsy", 32'(ldr_bsy), 32'd0);
    step();
    chk("ovfseq_no_launch", 32'(ldr_bsy), 32'd0);
  endtask

  task automatic seq_busy_launch();
    int pulses;
    pulses = 0;
    do_reset();
    setin(1'b1, 2'd0, 1'b1, 1'b0, 3'b000);
    step();
    for (int k = 0; k < 5; k++) begin
      setin(1'b0, 2'd0, 1'b0, 1'b1, 3'b000); #1;
      chk("bsyseq_start_held", 32'(start_proc), 32'd0);
      chk("bsyseq_ready", 32'(trk_ready), 32'd0);
      step();
    end
    setin(1'b0, 2'd0, 1'b0, 1'b0, 3'b000); #1;
    chk("bsyseq_ready_free", 32'(trk_ready), 32'd0);
    step();
    chk("bsyseq_start_fire", 32'(start_proc), 32'd1);
    setin(1'b0, 2'd0, 1'b0, 1'b1, 3'b000);
    for (int k = 0; k < 4; k++) begin
      if (start_proc === 1'b1) pulses++;
      step();
    end
    chk("bsyseq_pulse_count", 32'(pulses), 32'd1);
    setin(1'b0, 2'd0, 1'b0, 1'b0, 3'b000);
    step(); #1;
    chk("bsyseq_back_collect", 32'(trk_ready), 32'd1);
  endtask

  task automatic seq_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      setin(1'b1, 2'd0, (k == 2), 1'b0, 3'b000);
      step();
    end
    setin(1'b0, 2'd0, 1'b0, 1'b0, 3'b000);
    step();
    setin(1'b0, 2'd0, 1'b0, 1'b1, 3'b000);
    step(); #1;
    chk("rstseq_drain_zero_a", 32'(zero_a), 32'd0);
    chk("rstseq_drain_bsy", 32'(ldr_bsy), 32'd1);
    #1 res_n = 1'b0;
    #1;
    chk("rstseq_ready", 32'(trk_ready), 32'd1);
    chk("rstseq_zero_a", 32'(zero_a), 32'd1);
    chk("rstseq_ldr_bsy", 32'(ldr_bsy), 32'd0);
    chk("rstseq_start", 32'(start_proc), 32'd0);
    step();
    res_n = 1'b1;
    setin(1'b0, 2'd0, 1'b0, 1'b0, 3'b000);
    for (int k = 0; k < 4; k++) begin
      #1 chk("rstseq_no_start", 32'(start_proc), 32'd0);
      step();
    end
    // reset while LAUNCH is held off by a busy processor
    setin(1'b1, 2'd2, 1'b1, 1'b1, 3'b000);
    step();
    setin(1'b0, 2'd0, 1'b0, 1'b1, 3'b000);
    step();
    res_n = 1'b0;
    step();
    res_n = 1'b1;
    setin(1'b0, 2'd0, 1'b0, 1'b0, 3'b000);
    for (int k = 0; k < 4; k++) begin
      #1 chk("rstseq_launch_no_start", 32'(start_proc), 32'd0);
      chk("rstseq_launch_zero_c", 32'(zero_c), 32'd1);
      step();
    end
  endtask

  task automatic run_random(input int cycles);
    int         ph;
    int         wc [3];
    int         rc [3];
    logic [2:0] m_ovf;
    logic       m_sp;
    logic       nsp;
    logic       v, last, bsy, exp_wen;
    logic [1:0] blk;
    logic [2:0] en, ez;
    logic [AW-1:0] ra [3];
    do_reset();
    ph = 0; m_ovf = 3'b000; m_sp = 1'b0;
    for (int i = 0; i < 3; i++) begin wc[i] = 0; rc[i] = 0; end
    for (int c = 0; c < cycles; c++) begin
      v    = ($urandom_range(0, 9) < 7);
      blk  = 2'($urandom_range(0, 3));
      last = ($urandom_range(0, 47) == 0);
      bsy  = 1'($urandom_range(0, 1));
      en   = 3'($urandom_range(0, 7));
      setin(v, blk, last, bsy, en);
      #1;
      for (int i = 0; i < 3; i++) ez[i] = (rc[i] == wc[i]);
      exp_wen = (ph == 0) && v && (blk != 2'd3) && (wc[blk] < DEPTH);
      ra[0] = rd_addr_a; ra[1] = rd_addr_b; ra[2] = rd_addr_c;
      chk("rnd_ready", 32'(trk_ready), 32'(ph == 0));
      chk("rnd_ldr_bsy", 32'(ldr_bsy), 32'(ph != 0));
      chk("rnd_start", 32'(start_proc), 32'(m_sp));
      chk("rnd_zero", 32'({zero_c, zero_b, zero_a}), 32'(ez));
      chk("rnd_ovf", 32'(ovf), 32'(m_ovf));
      chk("rnd_wr_en", 32'(wr_en), 32'(exp_wen));
      if (exp_wen) begin
        chk("rnd_wr_blk", 32'(wr_blk), 32'(blk));
        chk("rnd_wr_addr", 32'(wr_addr), 32'(wc[blk]));
      end
      for (int i = 0; i < 3; i++)
        chk($sformatf("rnd_rd_addr%0d", i), 32'(ra[i]), 32'(rc[i] % DEPTH));
      nsp = 1'b0;
      case (ph)
        0: if (v) begin
             if (blk != 2'd3) begin
               if (wc[blk] < DEPTH) wc[blk]++;
               else m_ovf[blk] = 1'b1;
             end
             if (last) ph = 1;
           end
        1: if (!bsy) begin nsp = 1'b1; ph = 2; end
        default: begin
          for (int i = 0; i < 3; i++) if (en[i] && rc[i] < wc[i]) rc[i]++;
          if (ph == 2) begin
            if (bsy) ph = 3;
          end else if (!bsy) begin
            for (int i = 0; i < 3; i++) begin wc[i] = 0; rc[i] = 0; end
            m_ovf = 3'b000;
            ph = 0;
          end
        end
      endcase
      m_sp = nsp;
      step();
    end
  endtask

  initial begin
    run_table();
    seq_overflow();
    seq_busy_launch();
    seq_reset_mid();
    run_random(2000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
